pulse_seq_gen: RTL and testbench

PULSE_SEQ_GEN -- requirements
Module: pulse_seq_gen

---
 rtl/pulse_seq_gen.sv | 160 ++++++++++++++++
 tb/tb_pulse_seq_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pulse_seq_gen.sv
// Multi-channel phased pulse generator. The phase mode is stepped by debounced
// Next/Pre buttons or by a free-running auto-advance timer.

module btn_deb #(
  parameter int DEB_CYCLES = 8
) (
  input  logic sysclk,
  input  logic reset,
  input  logic i_raw,
  output logic o_evt
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic          r_meta, r_sync, r_deb, r_deb_d;
  logic [CW-1:0] r_cnt;

  // The count only advances while the synchronised input disagrees with the
  // debounced level; a single agreeing cycle starts the wait over.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_raw;
      r_sync  <= r_meta;
      r_deb_d <= r_deb;
      if (r_sync != r_deb) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_deb <= r_sync;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_evt = r_deb & ~r_deb_d;
endmodule

module pulse_lane #(
  parameter int CH        = 0,
  parameter int NUM_MODES = 4,
  parameter int PERIOD    = 16,
  parameter int PULSE_W   = 4,
  parameter int MW        = 2,
  parameter int PW        = 4
) (
  input  logic [PW-1:0] i_ph,
  input  logic [MW-1:0] i_mode,
  output logic          o_hit
);
  localparam int STEP = PERIOD / NUM_MODES;

  logic [31:0] w_off, w_diff;

  // The offset is reduced below PERIOD first, so adding PERIOD keeps the
  // difference non-negative and pulses stay contiguous across the phase wrap.
  assign w_off  = (32'(CH) * 32'(i_mode) * 32'(STEP)) % 32'(PERIOD);
  assign w_diff = (32'(i_ph) + 32'(PERIOD) - w_off) % 32'(PERIOD);
  assign o_hit  = w_diff < 32'(PULSE_W);
endmodule

module pulse_seq_gen #(
  parameter int  NUM_CH      = 2,
  parameter int  NUM_MODES   = 4,
  parameter int  PERIOD      = 16,
  parameter int  PULSE_W     = 4,
  parameter int  DEB_CYCLES  = 8,
  parameter int  AUTO_PERIOD = 64,
  localparam int MW          = $clog2(NUM_MODES)
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              Bt_Next,
  input  logic              Bt_Pre,
  input  logic              Bt_Auto,
  output logic [NUM_CH-1:0] Pulse,
  output logic [MW-1:0]     Mode,
  output logic              Auto_On
);
  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(AUTO_PERIOD);

  logic              w_next, w_pre, w_auto;
  logic              w_inc, w_dec, w_man, w_adv, w_chg;
  logic [MW-1:0]     w_mode_nxt;
  logic [NUM_CH-1:0] w_hit;

  logic [NUM_CH-1:0] r_pulse;
  logic [MW-1:0]     r_mode;
  logic              r_auto_on;
  logic [PW-1:0]     r_ph;
  logic [TW-1:0]     r_tmr;

  btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .sysclk(sysclk), .reset(reset), .i_raw(Bt_Next), .o_evt(w_next));
  btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pre (
    .sysclk(sysclk), .reset(reset), .i_raw(Bt_Pre), .o_evt(w_pre));
  btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_auto (
    .sysclk(sysclk), .reset(reset), .i_raw(Bt_Auto), .o_evt(w_auto));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    pulse_lane #(
      .CH(k), .NUM_MODES(NUM_MODES), .PERIOD(PERIOD),
      .PULSE_W(PULSE_W), .MW(MW), .PW(PW)
    ) u_lane (
      .i_ph(r_ph), .i_mode(r_mode), .o_hit(w_hit[k]));
  end

  // Simultaneous Next/Pre cancel; a manual press or an Auto toggle pre-empts
  // an auto advance falling in the same cycle.
  always_comb begin
    w_inc      = w_next & ~w_pre;
    w_dec      = w_pre & ~w_next;
    w_man      = w_next | w_pre;
    w_adv      = r_auto_on & ~w_auto & ~w_man & (r_tmr == TW'(AUTO_PERIOD - 1));
    w_chg      = w_inc | w_dec | w_adv;
    w_mode_nxt = r_mode;
    if (w_inc || w_adv)
      w_mode_nxt = (r_mode == MW'(NUM_MODES - 1)) ? '0 : r_mode + MW'(1);
    else if (w_dec)
      w_mode_nxt = (r_mode == '0) ? MW'(NUM_MODES - 1) : r_mode - MW'(1);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_pulse   <= '0;
      r_mode    <= '0;
      r_auto_on <= 1'b0;
      r_ph      <= '0;
      r_tmr     <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      if (w_auto)
        r_auto_on <= ~r_auto_on;
      if (w_auto || w_man || !r_auto_on || r_tmr == TW'(AUTO_PERIOD - 1))
        r_tmr <= '0;
      else
        r_tmr <= r_tmr + TW'(1);
      // A mode change restarts the frame with a blank output cycle.
      if (w_chg) begin
        r_ph    <= '0;
        r_pulse <= '0;
      end else begin
        r_ph    <= (r_ph == PW'(PERIOD - 1)) ? '0 : r_ph + PW'(1);
        r_pulse <= w_hit;
      end
    end
  end

  assign Pulse   = r_pulse;
  assign Mode    = r_mode;
  assign Auto_On = r_auto_on;
endmodule

// File: tb/tb_pulse_seq_gen.sv
// Self-checking bench for pulse_seq_gen at default parameters: table-driven
// button segments plus hand-written auto-advance and reset sequences.

module tb_pulse_seq_gen;
  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       Bt_Next = 1'b0, Bt_Pre = 1'b0, Bt_Auto = 1'b0;
  logic [1:0] Pulse;
  logic [1:0] Mode;
  logic       Auto_On;

  pulse_seq_gen dut (
    .sysclk(sysclk), .reset(reset),
    .Bt_Next(Bt_Next), .Bt_Pre(Bt_Pre), .Bt_Auto(Bt_Auto),
    .Pulse(Pulse), .Mode(Mode), .Auto_On(Auto_On));

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic nx;
    logic pr;
    int   cycles;
    int   chg_at;   // edge index (1-based) where Mode changes, 0 = none
    int   new_mode;
  } vec_t;

  typedef struct {
    logic [1:0] p;
    logic [1:0] m;
    logic       a;
  } exp_t;

  exp_t sb[$];
  vec_t vt[13];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_ph = 0, m_mode = 0;
  logic m_auto = 1'b0;
  logic [1:0] m_last = 2'b00;

  function automatic logic [1:0] ref_pulse(input int ph, input int mode);
    logic [1:0] r;
    for (int k = 0; k < 2; k++) begin
      int off, d;
      off  = (k * mode * 4) % 16;
      d    = (ph - off + 16) % 16;
      r[k] = (d < 4);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: predict, push, wait, pop, compare.
  task automatic step(input bit chg, input int nm);
    exp_t e;
    if (chg) begin
      e.p    = 2'b00;
      m_mode = nm;
      m_ph   = 0;
    end else begin
      e.p  = ref_pulse(m_ph, m_mode);
      m_ph = (m_ph + 1) % 16;
    end
    e.m = 2'(m_mode);
    e.a = m_auto;
    sb.push_back(e);
    @(posedge sysclk);
    #1;
    e = sb.pop_front();
    m_last = e.p;
    check("pulse", 32'(Pulse), 32'(e.p));
    check("mode", 32'(Mode), 32'(e.m));
    check("auto_on", 32'(Auto_On), 32'(e.a));
  endtask

  initial begin
    vt[0]  = '{1'b0, 1'b0, 32, 0, 0};  // free run, mode 0 in phase
    vt[1]  = '{1'b1, 1'b0, 20, 11, 1}; // Next held: one change
    vt[2]  = '{1'b0, 1'b0, 20, 0, 0};
    vt[3]  = '{1'b1, 1'b0, 5, 0, 0};   // glitch shorter than debounce
    vt[4]  = '{1'b0, 1'b0, 20, 0, 0};
    vt[5]  = '{1'b0, 1'b1, 20, 11, 0};
    vt[6]  = '{1'b0, 1'b0, 20, 0, 0};
    vt[7]  = '{1'b0, 1'b1, 20, 11, 3}; // 0 -> 3 wrap
    vt[8]  = '{1'b0, 1'b0, 20, 0, 0};
    vt[9]  = '{1'b1, 1'b1, 20, 0, 0};  // simultaneous cancel
    vt[10] = '{1'b0, 1'b0, 20, 0, 0};
    vt[11] = '{1'b1, 1'b0, 20, 11, 0}; // 3 -> 0 wrap
    vt[12] = '{1'b0, 1'b0, 20, 0, 0};

    #2 reset = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    check("rst_pulse", 32'(Pulse), 32'd0);
    check("rst_mode", 32'(Mode), 32'd0);
    check("rst_auto", 32'(Auto_On), 32'd0);
    #2 reset = 1'b1;

    for (int v = 0; v < 13; v++) begin
      Bt_Next = vt[v].nx;
      Bt_Pre  = vt[v].pr;
      for (int i = 1; i <= vt[v].cycles; i++)
        step(i == vt[v].chg_at, vt[v].new_mode);
    end
    Bt_Next = 1'b0;
    Bt_Pre  = 1'b0;

    // Auto mode: toggles on at the 11th edge, then advances every 64 edges.
    Bt_Auto = 1'b1;
    for (int i = 1; i <= 10; i++) step(1'b0, 0);
    m_auto = 1'b1;
    step(1'b0, 0);
    for (int j = 1; j <= 5; j++) begin
      for (int i = 1; i <= 64; i++) begin
        if (j == 1 && i == 10) Bt_Auto = 1'b0;
        step(i == 64, (m_mode + 1) % 4);
      end
    end

    // Move to a cycle where a pulse is high, then reset asynchronously.
    begin
      int guard = 0;
      do begin
        step(1'b0, 0);
        guard++;
      end while (m_last == 2'b00 && guard < 16);
      check("pulse_high_before_reset", 32'(m_last != 2'b00), 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("async_rst_pulse", 32'(Pulse), 32'd0);
    check("async_rst_mode", 32'(Mode), 32'd0);
    check("async_rst_auto", 32'(Auto_On), 32'd0);

    // Button held across reset release: no spurious mode change.
    Bt_Next = 1'b1;
    #2 reset = 1'b1;
    m_ph   = 0;
    m_mode = 0;
    m_auto = 1'b0;
    for (int i = 1; i <= 5; i++) step(1'b0, 0);
    Bt_Next = 1'b0;
    for (int i = 1; i <= 20; i++) step(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
